// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the upduino 6502 UART receive path.
//   uart_rx_state_t  : receiver FSM state encoding
//   UART_DEFAULT_DIV : clock cycles per bit for 25.175 MHz / 115200 baud
//   uart_div()       : clock cycles per bit for a clock/baud pair (truncating)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

  localparam int unsigned UART_DEFAULT_DIV = 32'd218;

  // Truncating division matches UART_DEFAULT_DIV (25175000/115200 = 218.5).
  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    int unsigned div_v;
    if (baud == 32'd0) begin
      div_v = 32'd0;
    end else begin
      div_v = clk_hz / baud;
    end
    return div_v;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO for received bytes. Entry 0 is the head,
// so the head output comes straight from a register. Only compiled when
// UART_RX_FIFO_EN is defined; the default build uses a holding register.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   push_i          : write push_data_i (ignored when full unless popping)
//   push_data_i     : byte to store
//   pop_i           : remove head (ignored when empty)
//   head_o          : oldest stored byte (registered)
//   valid_o         : FIFO not empty (registered)
//   full_o          : DEPTH entries stored
`ifdef UART_RX_FIFO_EN
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 32'd8,
  parameter int unsigned DEPTH = 32'd4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 32'd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q;
  logic             pop_ok_s, push_ok_s;
  logic [AW-1:0]    wr_idx_s;

  assign pop_ok_s  = pop_i & (count_q != CNT_ZERO);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok_s = push_i & ((count_q != CNT_FULL) | pop_ok_s);

  // Next-state: shift toward the head on pop, then write at the first free slot.
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_idx_s = AW'(count_q);
    if (pop_ok_s) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      wr_idx_s = AW'(count_q - CNT_ONE);
    end else begin
      wr_idx_s = AW'(count_q);
    end
    if (push_ok_s) begin
      mem_d[wr_idx_s] = push_data_i;
    end else begin
      mem_d[wr_idx_s] = mem_d[wr_idx_s];
    end
    count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
  end

  // Storage, occupancy and registered valid flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      count_q <= CNT_ZERO;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      valid_q <= (count_d != CNT_ZERO);
    end
  end

  assign head_o  = mem_q[0];
  assign valid_o = valid_q;
  assign full_o  = (count_q == CNT_FULL);

endmodule
`endif

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with valid/ready output.
// Optional feature macro: UART_RX_FIFO_EN -- when defined, received bytes go
// into a FIFO_DEPTH-entry FIFO (uart_rx_fifo); otherwise a single holding
// register is used.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial input, idle high
//   rx_data   : received byte, valid while rx_valid
//   rx_valid  : byte available
//   rx_ready  : consumer accepts (transfer on rx_valid && rx_ready)
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte dropped because storage was full
//   busy      : receiver FSM not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = UART_DEFAULT_DIV,
  parameter int unsigned FIFO_DEPTH = 32'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLK_DIV / 32'd2 - 32'd1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLK_DIV - 32'd1);

  if (CLK_DIV < 32'd4 || CLK_DIV > 32'd65535) begin : g_bad_clk_div
    $error("uart_rx: CLK_DIV must be in 4..65535");
  end
  if (FIFO_DEPTH < 32'd2 || (FIFO_DEPTH & (FIFO_DEPTH - 32'd1)) != 32'd0) begin : g_bad_fifo_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  logic             sync1_q, sync2_q, rx_s;
  logic [1:0]       fill_q;
  logic             armed_q;
  uart_rx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       sh_q, sh_d;
  logic             push_s, ferr_s, pop_s, full_s, overrun_s;
  logic             frame_err_q, overrun_q, busy_q;

  // Two-flop synchronizer on the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end
  assign rx_s = sync2_q;

  // The synchronizer's reset value is not a real line level: wait until it has
  // refilled, then arm start detection only once the line is seen high, so a
  // line that is low across reset does not look like a new start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & rx_s);
    end
  end

  // Receiver FSM next-state, bit timer and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    sh_d    = sh_q;
    push_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          state_d = IDLE;            // false start: line back high mid-bit
        end else begin
          state_d = DATA;
          cnt_d   = FULL_M1;
          bitn_d  = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          sh_d   = {rx_s, sh_q[7:1]};  // LSB arrives first
          cnt_d  = FULL_M1;
          bitn_d = bitn_q + 3'd1;
          if (bitn_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end
      end
      STOP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          // Leaving at mid-stop-bit lets the next start edge follow immediately.
          push_s  = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_s  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      bitn_q      <= 3'd0;
      sh_q        <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitn_q      <= bitn_d;
      sh_q        <= sh_d;
      frame_err_q <= ferr_s;
      overrun_q   <= overrun_s;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign pop_s = rx_valid & rx_ready;

`ifdef UART_RX_FIFO_EN
  uart_rx_fifo #(
    .WIDTH (32'd8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push_s),
    .push_data_i (sh_q),
    .pop_i       (pop_s),
    .head_o      (rx_data),
    .valid_o     (rx_valid),
    .full_o      (full_s)
  );
`else
  logic [7:0] hold_q;
  logic       hold_valid_q;

  // Single-entry holding register; a pop on the push edge frees the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
    end else if (push_s && (!hold_valid_q || pop_s)) begin
      hold_q       <= sh_q;
      hold_valid_q <= 1'b1;
    end else if (pop_s) begin
      hold_valid_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_q;
    end
  end

  assign full_s   = hold_valid_q;
  assign rx_data  = hold_q;
  assign rx_valid = hold_valid_q;
`endif

  assign overrun_s = push_s & full_s & ~pop_s;

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int D  = 218;
  localparam int H  = D / 2;
  localparam int FD = 4;
`ifdef UART_RX_FIFO_EN
  localparam int STORE = FD;
`else
  localparam int STORE = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  uart_rx #(.CLK_DIV(D), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: observes the output interface on the falling edge.
  logic [7:0] got_q[$];
  int n_valid = 0, n_ferr = 0, n_ovr = 0, first_valid_cyc = -1;
  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_valid == 0) first_valid_cyc = cyc;
      n_valid++;
    end
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  task automatic clear_mon();
    got_q.delete();
    n_valid = 0; n_ferr = 0; n_ovr = 0; first_valid_cyc = -1;
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v, input int cycles);
    rx = v;
    tick(cycles);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_cycles, input logic stop_v);
    send_bit(1'b0, D);
    for (int i = 0; i < 8; i++) send_bit(b[i], D);
    send_bit(stop_v, stop_cycles);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
    tick(3);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick(10);
    n_tests++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, rx_valid); end
    n_tests++; if (uart_div(32'd25175000, 32'd115200) !== 32'd218) begin n_fail++; $display("FAIL uart_div: got %0d want 218", uart_div(32'd25175000, 32'd115200)); end
  endtask

  task automatic test_single();
    int c0;
    clear_mon(); rx_ready = 1'b1;
    tick(20);
    c0 = cyc;
    send_frame(8'h23, D, 1'b1);
    tick(20);
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    n_tests++; if (got_q.size() < 1 || got_q[0] !== 8'h23) begin n_fail++; $display("FAIL single_data: got %h want 23", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    n_tests++; if (n_valid != 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", n_valid); end
    n_tests++; if (n_ferr != 0 || n_ovr != 0) begin n_fail++; $display("FAIL single_errors: ferr=%0d ovr=%0d want 0 0", n_ferr, n_ovr); end
    // line falls 1 cycle before t0; valid visible after edge t0+2+D/2+9*D
    n_tests++; if (first_valid_cyc - c0 != 3 + H + 9 * D) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", first_valid_cyc - c0, 3 + H + 9 * D); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    clear_mon(); rx_ready = 1'b1;
    exp_q = '{8'h0D, 8'h0A, 8'h60};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) send_frame(exp_q[i], D, 1'b1);
    tick(20);
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_tests++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    n_tests++; if (n_ferr != 0 || n_ovr != 0) begin n_fail++; $display("FAIL b2b_errors: ferr=%0d ovr=%0d want 0 0", n_ferr, n_ovr); end
  endtask

  task automatic test_glitch();
    clear_mon(); rx_ready = 1'b1;
    rx = 1'b0; tick(50);
    rx = 1'b1; tick(10);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    tick(H + 20);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    n_tests++; if (n_valid != 0 || n_ferr != 0) begin n_fail++; $display("FAIL glitch_outputs: valid=%0d ferr=%0d want 0 0", n_valid, n_ferr); end
  endtask

  task automatic test_frame_err();
    clear_mon(); rx_ready = 1'b1;
    send_frame(8'h55, 3 * D, 1'b0);
    n_tests++; if (n_ferr != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr); end
    n_tests++; if (n_valid != 0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d want 0", n_valid); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
    rx = 1'b1; tick(5);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_break_exit: got %b want 0", busy); end
    clear_mon();
    send_frame(8'h23, D, 1'b1);
    tick(20);
    n_tests++; if (got_q.size() != 1 || got_q[0] !== 8'h23) begin n_fail++; $display("FAIL ferr_recover: got %0d bytes first %h want 1 byte 23", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    n_tests++; if (n_ferr != 0) begin n_fail++; $display("FAIL ferr_recover_err: got %0d want 0", n_ferr); end
  endtask

  task automatic test_overrun();
    logic [7:0] model_q[$];
    logic [7:0] b;
    int exp_ovr = 0;
    clear_mon(); rx_ready = 1'b0;
    tick(5);
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i * 17);
      if (model_q.size() < STORE) model_q.push_back(b); else exp_ovr++;
      send_frame(b, D, 1'b1);
    end
    tick(20);
    n_tests++; if (n_ovr != exp_ovr) begin n_fail++; $display("FAIL ovr_pulses: got %0d want %0d", n_ovr, exp_ovr); end
    n_tests++; if (rx_valid !== 1'b1 || rx_data !== model_q[0]) begin n_fail++; $display("FAIL ovr_head: valid=%b data=%h want 1 %h", rx_valid, rx_data, model_q[0]); end
    rx_ready = 1'b1;
    tick(STORE + 5);
    n_tests++; if (got_q.size() != model_q.size()) begin n_fail++; $display("FAIL ovr_drain_count: got %0d want %0d", got_q.size(), model_q.size()); end
    foreach (model_q[i]) begin
      n_tests++; if (i >= got_q.size() || got_q[i] !== model_q[i]) begin n_fail++; $display("FAIL ovr_drain[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, model_q[i]); end
    end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: got %b want 0", rx_valid); end
  endtask

  task automatic test_full_pop();
    logic [7:0] model_q[$];
    logic [7:0] b;
    clear_mon(); rx_ready = 1'b0;
    for (int i = 0; i < STORE; i++) begin
      b = 8'($urandom); model_q.push_back(b);
      send_frame(b, D, 1'b1);
    end
    b = 8'($urandom); model_q.push_back(b);
    // ready high for exactly the cycle whose closing edge is the stop sample
    fork
      send_frame(b, D, 1'b1);
      begin tick(2 + H + 9 * D); rx_ready = 1'b1; tick(1); rx_ready = 1'b0; end
    join
    tick(5);
    n_tests++; if (n_ovr != 0) begin n_fail++; $display("FAIL fullpop_ovr: got %0d want 0", n_ovr); end
    n_tests++; if (got_q.size() != 1 || got_q[0] !== model_q[0]) begin n_fail++; $display("FAIL fullpop_first: got %0d bytes first %h want 1 byte %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, model_q[0]); end
    rx_ready = 1'b1;
    tick(STORE + 5);
    n_tests++; if (got_q.size() != model_q.size()) begin n_fail++; $display("FAIL fullpop_count: got %0d want %0d", got_q.size(), model_q.size()); end
    foreach (model_q[i]) begin
      n_tests++; if (i >= got_q.size() || got_q[i] !== model_q[i]) begin n_fail++; $display("FAIL fullpop_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, model_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_mon(); rx_ready = 1'b1;
    b = 8'hA5;
    send_bit(1'b0, D);
    for (int i = 0; i < 4; i++) send_bit(b[i], D);
    rx = b[4]; tick(H);
    rst = 1'b1; tick(1); rst = 1'b0;
    n_tests++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs: valid=%b data=%h ferr=%b ovr=%b busy=%b want 0 00 0 0 0", rx_valid, rx_data, frame_err, overrun, busy);
    end
    tick(D - H);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_low_line: busy=%b want 0", busy); end
    rx = 1'b1; tick(2 * D);
    n_tests++; if (n_valid != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_byte: valid=%0d busy=%b want 0 0", n_valid, busy); end
    clear_mon();
    send_frame(8'h0D, D, 1'b1);
    tick(20);
    n_tests++; if (got_q.size() != 1 || got_q[0] !== 8'h0D) begin n_fail++; $display("FAIL midrst_recover: got %0d bytes first %h want 1 byte 0d", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_random();
    logic [7:0] model_q[$];
    logic [7:0] b;
    bit done = 1'b0;
    clear_mon();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          b = 8'($urandom); model_q.push_back(b);
          send_frame(b, D, 1'b1);
          tick(int'($urandom_range(0, 40)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin rx_ready = 1'($urandom_range(0, 1)); tick(1); end
      end
    join
    rx_ready = 1'b1;
    tick(10);
    n_tests++; if (got_q.size() != model_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), model_q.size()); end
    foreach (model_q[i]) begin
      n_tests++; if (i >= got_q.size() || got_q[i] !== model_q[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, model_q[i]); end
    end
    n_tests++; if (n_ovr != 0 || n_ferr != 0) begin n_fail++; $display("FAIL rand_errors: ovr=%0d ferr=%0d want 0 0", n_ovr, n_ferr); end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
